// File: rtl/palette_colorizer.sv
// Two-stage VGA colorizer: resolves world/icon layer codes to a palette index,
// then looks the index up in a double-buffered (shadow/active) RGB palette.
module palette_colorizer #(
  parameter int   COLOR_W   = 4,
  parameter int   WORLD_W   = 2,
  parameter int   ICON_W    = 2,
  parameter int   N_ICONS   = 2,
  parameter int   PAL_AW    = 5,
  parameter logic SYNC_IDLE = 1'b1
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        video_on,
  input  logic                        hsync_in,
  input  logic                        vsync_in,
  input  logic [WORLD_W-1:0]          world_pixel,
  input  logic [N_ICONS*ICON_W-1:0]   icon_pixel,
  input  logic                        frame_start,
  input  logic                        shadow_en,
  input  logic                        pal_we,
  input  logic [PAL_AW-1:0]           pal_addr,
  input  logic [3*COLOR_W-1:0]        pal_wdata,
  output logic [3*COLOR_W-1:0]        pal_rdata,
  output logic [COLOR_W-1:0]          red,
  output logic [COLOR_W-1:0]          green,
  output logic [COLOR_W-1:0]          blue,
  output logic                        hsync_out,
  output logic                        vsync_out,
  output logic                        video_on_out
);

  localparam int RGB_W      = 3 * COLOR_W;
  localparam int N_WORLD    = 1 << WORLD_W;
  localparam int N_CODE     = 1 << ICON_W;
  localparam int N_ICON_ENT = N_ICONS * N_CODE;
  localparam int N_ENT      = 1 << PAL_AW;
  localparam logic [COLOR_W-1:0] C1 = '1;
  localparam logic [COLOR_W-1:0] C0 = '0;

  function automatic logic [RGB_W-1:0] f_reset_val(input int a);
    logic [RGB_W-1:0] v;
    v = '0;
    if (a < N_WORLD) begin
      case (a)
        0:       v = {C1, C1, C1};
        2:       v = {C1, C0, C0};
        default: v = '0;
      endcase
    end else if (a < N_WORLD + N_ICON_ENT) begin
      case ((a - N_WORLD) % N_CODE)
        1:       v = {C1, C1, C0};
        2:       v = {C0, C1, C0};
        3:       v = {C0, C0, C1};
        default: v = '0;
      endcase
    end
    return v;
  endfunction

  // Icon code 0 is transparent, so its slot never holds a colour.
  function automatic logic f_mapped(input int a);
    return (a < N_WORLD) ||
           ((a < N_WORLD + N_ICON_ENT) && (((a - N_WORLD) % N_CODE) != 0));
  endfunction

  logic [RGB_W-1:0]  r_shadow [N_ENT];
  logic [RGB_W-1:0]  r_active [N_ENT];
  logic [RGB_W-1:0]  r_pal_rdata;
  logic [PAL_AW-1:0] r_idx1;
  logic              r_vid1, r_hs1, r_vs1;
  logic [RGB_W-1:0]  r_rgb;
  logic              r_vid2, r_hs2, r_vs2;
  logic              w_wr_ok;
  logic [PAL_AW-1:0] w_idx;

  assign w_wr_ok = pal_we && f_mapped(int'(pal_addr));

  // Unmapped entries reset to zero and are never written, so they read as 0.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int e = 0; e < N_ENT; e++) begin
        r_shadow[e] <= f_reset_val(e);
        r_active[e] <= f_reset_val(e);
      end
    end else begin
      if (shadow_en && frame_start) begin
        for (int e = 0; e < N_ENT; e++) begin
          r_active[e] <= r_shadow[e];
        end
      end
      if (w_wr_ok) begin
        r_shadow[pal_addr] <= pal_wdata;
        if (!shadow_en) begin
          r_active[pal_addr] <= pal_wdata;
        end
      end
    end
  end

  always_comb begin
    w_idx = PAL_AW'(world_pixel);
    for (int k = N_ICONS - 1; k >= 0; k--) begin
      if (icon_pixel[k*ICON_W +: ICON_W] != '0) begin
        w_idx = PAL_AW'(N_WORLD + k * N_CODE) + PAL_AW'(icon_pixel[k*ICON_W +: ICON_W]);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pal_rdata <= '0;
      r_idx1      <= '0;
      r_vid1      <= 1'b0;
      r_hs1       <= SYNC_IDLE;
      r_vs1       <= SYNC_IDLE;
      r_rgb       <= '0;
      r_vid2      <= 1'b0;
      r_hs2       <= SYNC_IDLE;
      r_vs2       <= SYNC_IDLE;
    end else begin
      r_pal_rdata <= r_shadow[pal_addr];
      r_idx1      <= w_idx;
      r_vid1      <= video_on;
      r_hs1       <= hsync_in;
      r_vs1       <= vsync_in;
      r_rgb       <= r_vid1 ? r_active[r_idx1] : '0;
      r_vid2      <= r_vid1;
      r_hs2       <= r_hs1;
      r_vs2       <= r_vs1;
    end
  end

  assign pal_rdata          = r_pal_rdata;
  assign {red, green, blue} = r_rgb;
  assign hsync_out          = r_hs2;
  assign vsync_out          = r_vs2;
  assign video_on_out       = r_vid2;

endmodule

// File: tb/tb_palette_colorizer.sv
// Bench for palette_colorizer: directed steps plus random traffic, checked
// against a palette/pipeline reference model held in plain arrays.
module tb_palette_colorizer;

  localparam int   COLOR_W   = 4;
  localparam int   WORLD_W   = 2;
  localparam int   ICON_W    = 2;
  localparam int   N_ICONS   = 2;
  localparam int   PAL_AW    = 5;
  localparam logic SYNC_IDLE = 1'b1;

  logic        clk;
  logic        resetn;
  logic        video_on, hsync_in, vsync_in;
  logic [1:0]  world_pixel;
  logic [3:0]  icon_pixel;
  logic        frame_start, shadow_en, pal_we;
  logic [4:0]  pal_addr;
  logic [11:0] pal_wdata;
  logic [11:0] pal_rdata;
  logic [3:0]  red, green, blue;
  logic        hsync_out, vsync_out, video_on_out;

  palette_colorizer #(
    .COLOR_W(COLOR_W), .WORLD_W(WORLD_W), .ICON_W(ICON_W),
    .N_ICONS(N_ICONS), .PAL_AW(PAL_AW), .SYNC_IDLE(SYNC_IDLE)
  ) dut (
    .clk(clk), .resetn(resetn), .video_on(video_on), .hsync_in(hsync_in),
    .vsync_in(vsync_in), .world_pixel(world_pixel), .icon_pixel(icon_pixel),
    .frame_start(frame_start), .shadow_en(shadow_en), .pal_we(pal_we),
    .pal_addr(pal_addr), .pal_wdata(pal_wdata), .pal_rdata(pal_rdata),
    .red(red), .green(green), .blue(blue), .hsync_out(hsync_out),
    .vsync_out(vsync_out), .video_on_out(video_on_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int unsigned m_sh [32];
  int unsigned m_ac [32];
  logic [14:0] exp_pix;
  logic [14:0] pend_pix;
  logic [11:0] exp_rd;

  function automatic int unsigned ref_reset(input int a);
    if (a == 0) return 32'hFFF;
    if (a == 2) return 32'hF00;
    if (a >= 4 && a < 12) begin
      case ((a - 4) % 4)
        1: return 32'hFF0;
        2: return 32'h0F0;
        3: return 32'h00F;
        default: return 0;
      endcase
    end
    return 0;
  endfunction

  function automatic bit ref_mapped(input int a);
    return (a < 4) || (a < 12 && ((a - 4) % 4) != 0);
  endfunction

  function automatic logic [14:0] obs_pix();
    return {red, green, blue, hsync_out, vsync_out, video_on_out};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int a = 0; a < 32; a++) begin
      m_sh[a] = ref_reset(a);
      m_ac[a] = ref_reset(a);
    end
    pend_pix = {12'h000, SYNC_IDLE, SYNC_IDLE, 1'b0};
    exp_pix  = pend_pix;
    exp_rd   = 12'h000;
  endtask

  // One clock edge of the reference: palette update, then pixel resolution.
  task automatic model_edge();
    int unsigned old [32];
    int idx;
    int code;
    bit found;
    old = m_sh;
    exp_rd = 12'(old[pal_addr]);
    if (shadow_en && frame_start) m_ac = old;
    if (pal_we && ref_mapped(int'(pal_addr))) begin
      m_sh[pal_addr] = pal_wdata;
      if (!shadow_en) m_ac[pal_addr] = pal_wdata;
    end
    exp_pix = pend_pix;
    idx = int'(world_pixel);
    found = 0;
    for (int k = 0; k < N_ICONS; k++) begin
      code = (int'(icon_pixel) >> (k * ICON_W)) & 3;
      if (code != 0 && !found) begin
        idx = 4 + 4 * k + code;
        found = 1;
      end
    end
    pend_pix = {video_on ? 12'(m_ac[idx]) : 12'h000, hsync_in, vsync_in, video_on};
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check("pix", 32'(obs_pix()), 32'(exp_pix));
    check("rdata", 32'(pal_rdata), 32'(exp_rd));
  endtask

  task automatic check_rgb(input string tag, input logic [11:0] expv);
    check(tag, 32'({red, green, blue}), 32'(expv));
  endtask

  task automatic check_reset_outputs(input string tag);
    check(tag, 32'({red, green, blue, video_on_out, hsync_out, vsync_out, pal_rdata}),
          32'({12'h000, 1'b0, SYNC_IDLE, SYNC_IDLE, 12'h000}));
  endtask

  logic [11:0] wexp [4];

  initial begin
    wexp[0] = 12'hFFF; wexp[1] = 12'h000; wexp[2] = 12'hF00; wexp[3] = 12'h000;
    resetn = 1'b0;
    video_on = 0; hsync_in = 0; vsync_in = 0; world_pixel = 0; icon_pixel = 0;
    frame_start = 0; shadow_en = 0; pal_we = 0; pal_addr = 0; pal_wdata = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_state");
    resetn = 1'b1;

    // World sweep with no icons
    video_on = 1;
    for (int w = 0; w < 4; w++) begin
      world_pixel = 2'(w);
      hsync_in = w[0];
      vsync_in = w[1];
      cycle(); cycle();
      check_rgb("world_sweep", wexp[w]);
      check("sync_delay", 32'({hsync_out, vsync_out}), 32'({w[0], w[1]}));
    end

    // Icon priority and blanking
    world_pixel = 0;
    icon_pixel = {2'd2, 2'd0};
    cycle(); cycle();
    check_rgb("icon_layer1", 12'h0F0);
    icon_pixel = {2'd2, 2'd3};
    cycle(); cycle();
    check_rgb("icon_layer0_wins", 12'h00F);
    video_on = 0;
    cycle(); cycle();
    check_rgb("blanked", 12'h000);
    check("blank_flag", 32'(video_on_out), 32'd0);

    // Direct write
    video_on = 1; icon_pixel = 0; world_pixel = 0;
    shadow_en = 0; pal_we = 1; pal_addr = 0; pal_wdata = 12'h12A;
    cycle();
    pal_we = 0;
    cycle();
    check_rgb("direct_write", 12'h12A);
    check("readback", 32'(pal_rdata), 32'h12A);

    // Shadowed write, then write coinciding with frame_start
    shadow_en = 1; world_pixel = 2; pal_we = 1; pal_addr = 2; pal_wdata = 12'h0F0;
    cycle();
    pal_we = 0;
    cycle();
    check_rgb("shadow_not_active", 12'hF00);
    cycle();
    check_rgb("shadow_still_old", 12'hF00);
    frame_start = 1;
    cycle();
    frame_start = 0;
    cycle();
    check_rgb("frame_start_copy", 12'h0F0);
    pal_we = 1; pal_wdata = 12'h555; frame_start = 1;
    cycle();
    pal_we = 0; frame_start = 0;
    cycle();
    check_rgb("same_cycle_write_old", 12'h0F0);
    cycle();
    check_rgb("same_cycle_write_hold", 12'h0F0);
    check("readback_shadow", 32'(pal_rdata), 32'h555);
    frame_start = 1;
    cycle();
    frame_start = 0;
    cycle();
    check_rgb("next_frame_start", 12'h555);

    // Unmapped addresses
    shadow_en = 0; world_pixel = 0;
    pal_we = 1; pal_addr = 5'd4; pal_wdata = 12'hFFF;
    cycle();
    pal_addr = 5'd31;
    cycle();
    pal_we = 0; pal_addr = 5'd4;
    cycle();
    check("unmapped_rd_code0", 32'(pal_rdata), 32'h0);
    pal_addr = 5'd31;
    cycle();
    check("unmapped_rd_31", 32'(pal_rdata), 32'h0);
    check_rgb("unmapped_no_effect", 12'h12A);

    // Asynchronous reset mid-frame
    hsync_in = 0; vsync_in = 0; pal_addr = 0;
    cycle(); cycle();
    #2;
    resetn = 1'b0;
    #1;
    check_reset_outputs("async_reset_immediate");
    model_reset();
    @(posedge clk);
    #1;
    check_reset_outputs("reset_held");
    resetn = 1'b1;
    cycle(); cycle();
    check_rgb("after_reset_world0", 12'hFFF);

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      video_on    = ($urandom_range(0, 99) < 80);
      hsync_in    = 1'($urandom);
      vsync_in    = 1'($urandom);
      world_pixel = 2'($urandom);
      for (int k = 0; k < N_ICONS; k++) begin
        icon_pixel[k*ICON_W +: ICON_W] = $urandom_range(0, 1) ? 2'($urandom_range(1, 3)) : 2'd0;
      end
      pal_we      = ($urandom_range(0, 99) < 20);
      pal_addr    = 5'($urandom);
      pal_wdata   = 12'($urandom);
      shadow_en   = ($urandom_range(0, 99) < 60);
      frame_start = ($urandom_range(0, 99) < 5);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/palette_colorizer.md
Name: palette_colorizer

Overview:
- Parameterised, pipelined VGA colorizer. Resolves one world pixel and N_ICONS overlaid icon pixels into an RGB colour through software-writable palette registers.
- Sits between the pixel sources (world map ROM, icon ROMs, dtg) and the VGA connector.
- Delays sync and blanking by the same latency as colour so all outputs stay aligned.
- Supports double-buffered palette updates that take effect only at frame start.

Parameters:
- COLOR_W, 4, bits per colour channel.
- WORLD_W, 2, world pixel code width (2^WORLD_W world palette entries).
- ICON_W, 2, icon pixel code width per layer; code 0 = transparent.
- N_ICONS, 2, number of icon layers (1..4); layer 0 has highest priority.
- PAL_AW, 5, palette address width; must satisfy 2^PAL_AW >= 2^WORLD_W + N_ICONS*2^ICON_W.
- SYNC_IDLE, 1, reset value of hsync_out/vsync_out.

Ports:
- clk  in  1  pixel clock.
- resetn  in  1  asynchronous active-low reset.
- video_on  in  1  from dtg; 0 = blanking.
- hsync_in  in  1  from dtg.
- vsync_in  in  1  from dtg.
- world_pixel  in  WORLD_W  world map code.
- icon_pixel  in  N_ICONS*ICON_W  icon codes; layer k in bits [k*ICON_W +: ICON_W].
- frame_start  in  1  one-cycle pulse at start of vertical blanking.
- shadow_en  in  1  1 = palette writes deferred to next frame_start.
- pal_we  in  1  palette write strobe.
- pal_addr  in  PAL_AW  palette entry address.
- pal_wdata  in  3*COLOR_W  {R,G,B} write data.
- pal_rdata  out  3*COLOR_W  registered read-back of shadow[pal_addr].
- red, green, blue  out  COLOR_W each  registered colour.
- hsync_out, vsync_out, video_on_out  out  1 each  inputs delayed 2 cycles.

Behaviour:
Address map:
- World entry w is at address w.
- Icon layer k, code c is at 2^WORLD_W + k*2^ICON_W + c.
- Slots with c=0 and all addresses beyond the last icon slot are unmapped: writes ignored, reads return 0.

Storage:
- Two register banks, shadow and active.
- Reset values, identical in both banks, with COLOR_W=4 (scale: all-ones/all-zeros per channel for other widths):
  - World 0 = F,F,F; world 1 = 0,0,0; world 2 = F,0,0; other world entries = 0.
  - Icon code 1 = F,F,0; code 2 = 0,F,0; code 3 = 0,0,F, for every layer; higher codes = 0.

Writes:
- shadow_en=0: pal_we writes shadow and active at the same edge.
- shadow_en=1: pal_we writes shadow only.
- frame_start=1 with shadow_en=1: active <= shadow as it was before the edge. A write in the same cycle lands in shadow only and becomes active at the following frame_start.
- frame_start with shadow_en=0: no effect.

Read-back:
- pal_rdata updates 1 cycle after pal_addr is presented.
- Reset value 0.

Pipeline (fixed latency 2 cycles for all outputs):
- Stage 1 registers video_on, hsync_in, vsync_in and the resolved palette index:
  - Winner = lowest-numbered layer k with a nonzero code → index of icon entry (k, code).
  - All icon codes 0 → world entry world_pixel.
- Stage 2 registers the active-palette lookup onto red/green/blue. If the stage-1 video_on is 0, the outputs are 0.
- Palette write at edge t (direct, or frame_start copy) is used by every pixel sampled at edge >= t. Pixels sampled before t use the old value.

Reset (asserted asynchronously, any time, including mid-frame):
- red/green/blue = 0, video_on_out = 0, pal_rdata = 0.
- hsync_out = vsync_out = SYNC_IDLE.
- Pipeline registers cleared; both banks return to their reset values.
- First valid pixel appears 2 cycles after the first edge following resetn deassertion.

Test Plan:
- Reset, no writes, video_on=1, world_pixel sweeps 0..3 with icons 0 → after 2 cycles RGB = FFF, 000, F00, 000; hsync_out/vsync_out equal hsync_in/vsync_in delayed 2 cycles.
- icon layer1=2, layer0=0, world=0 → RGB 0F0. Then layer0=3 in the same pixel → 00F (layer 0 wins). video_on=0 with the same inputs → 000.
- shadow_en=0, write addr 0 = 0x12A, world_pixel=0 applied the same cycle → output 12A two cycles later. Read-back addr 0 → 0x12A after 1 cycle.
- shadow_en=1, write addr 2 = 0x0F0 → world_pixel=2 still F00 until frame_start pulse. Write + frame_start in the same cycle to addr 2 = 0x555 → 0F0 active, 555 appears only after the next frame_start.
- Write to unmapped addresses (icon code-0 slot, address 31) → no output change, read-back returns 0.
- Assert resetn low mid-frame after palette writes → outputs go to 0/SYNC_IDLE immediately (without a clock edge). After release, world 0 outputs FFF again.
